uart_rx: RTL and testbench

UART receiver: the downstream stage of the team's UART transmitter. Converts the asynchronous 8N1 serial line back into parallel bytes. It synchronises the line, detects the start bit, samples each bit at mid-bit, and checks the stop bit. Received bytes are presented on a one-entry valid/ready output buffer, with framing-error and overrun reporting.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 24 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame bit levels, data width and receiver state encoding.
// The transmitter reuses the bit-level constants.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial input plus byte-buffer handshake of the UART receiver.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 i_rx;
  logic                 i_ready;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 o_busy;

  modport master (
    input  i_rx, i_ready,
    output o_data, o_valid, o_frame_err, o_overrun, o_busy
  );

  modport slave (
    output i_rx, i_ready,
    input  o_data, o_valid, o_frame_err, o_overrun, o_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to RST_VAL so that
// idle-high lines do not fake an edge when reset is released.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, one-entry valid/ready
// output buffer with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD            = 115200
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_rx_if.master bus
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = $clog2(CYCLES_PER_BIT);

  localparam logic [CW-1:0] BIT_END  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE      = RX_IDLE;
  localparam logic [2:0] S_START     = RX_START;
  localparam logic [2:0] S_DATA      = RX_DATA;
  localparam logic [2:0] S_STOP      = RX_STOP;
  localparam logic [2:0] S_WAIT_HIGH = RX_WAIT_HIGH;

  logic [0:0]           rx_s;
  logic [2:0]           state_r, state_nxt_s;
  logic [CW-1:0]        clk_cnt_r, clk_cnt_nxt_s;
  logic [2:0]           bit_idx_r, bit_idx_nxt_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_nxt_s;
  logic                 stop_smp_s;

  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.i_rx),
    .q       (rx_s)
  );

  // Next-state, counter and shift-register logic of the frame decoder.
  always_comb begin
    state_nxt_s   = state_r;
    clk_cnt_nxt_s = clk_cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shreg_nxt_s   = shreg_r;
    stop_smp_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        clk_cnt_nxt_s = '0;
        bit_idx_nxt_s = 3'd0;
        if (rx_s == START_BIT) begin
          state_nxt_s = S_START;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: begin
        if (clk_cnt_r == HALF_END) begin
          clk_cnt_nxt_s = '0;
          if (rx_s == START_BIT) begin
            state_nxt_s = S_DATA;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + CW'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_r == BIT_END) begin
          clk_cnt_nxt_s          = '0;
          shreg_nxt_s[bit_idx_r] = rx_s;
          if (bit_idx_r == LAST_IDX) begin
            state_nxt_s = S_STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + CW'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt_r == BIT_END) begin
          clk_cnt_nxt_s = '0;
          stop_smp_s    = 1'b1;
          // Leaving at mid-stop lets a following start edge be caught early.
          if (rx_s == STOP_BIT) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_WAIT_HIGH;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        clk_cnt_nxt_s = '0;
        if (rx_s == STOP_BIT) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT_HIGH;
        end
      end
      default: begin
        state_nxt_s   = S_IDLE;
        clk_cnt_nxt_s = '0;
        bit_idx_nxt_s = 3'd0;
      end
    endcase
  end

  // Frame decoder state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      clk_cnt_r <= '0;
      bit_idx_r <= 3'd0;
      shreg_r   <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clk_cnt_r <= clk_cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shreg_r   <= shreg_nxt_s;
      busy_r    <= (state_nxt_s != S_IDLE);
    end
  end

  // One-entry output buffer with error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r      <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (stop_smp_s && (rx_s == STOP_BIT)) begin
      frame_err_r <= 1'b0;
      if (!valid_r || bus.i_ready) begin
        data_r    <= shreg_r;
        valid_r   <= 1'b1;
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (stop_smp_s) begin
      frame_err_r <= 1'b1;
      overrun_r   <= 1'b0;
      valid_r     <= valid_r && !bus.i_ready;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      valid_r     <= valid_r && !bus.i_ready;
    end
  end

  assign bus.o_data      = data_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_frame_err = frame_err_r;
  assign bus.o_overrun   = overrun_r;
  assign bus.o_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: a cycle-indexed event model of the
// byte buffer is compared against the DUT on every falling clock edge.
module tb_uart_rx;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  uart_rx_if u_if ();

  uart_rx #(
    .CLOCK_FREQUENCY (16),
    .BAUD            (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Scheduled model events keyed by cycle: 1 = good byte, 2 = framing error.
  int         ev_kind [int];
  logic [7:0] ev_byte [int];
  logic       busy_ev [int];

  // DUT history keyed by cycle, for hand-computed pin checks.
  logic       h_valid [int];
  logic       h_fe    [int];
  logic       h_ov    [int];
  logic       h_busy  [int];
  logic [7:0] h_data  [int];

  logic       mv = 1'b0, mfe = 1'b0, mov = 1'b0, mbusy = 1'b0, rdy_prev = 1'b1;
  logic [7:0] md = 8'h00;
  bit         rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Model update and per-cycle compare.
  always @(negedge clk) begin
    if (!reset_n) begin
      mv = 1'b0; md = 8'h00; mfe = 1'b0; mov = 1'b0; mbusy = 1'b0;
    end else begin
      mfe = 1'b0;
      mov = 1'b0;
      if (ev_kind.exists(cyc) && ev_kind[cyc] == 1) begin
        if (!mv || rdy_prev) begin
          md = ev_byte[cyc];
          mv = 1'b1;
        end else begin
          mov = 1'b1;
        end
      end else begin
        if (ev_kind.exists(cyc)) mfe = 1'b1;
        mv = mv && !rdy_prev;
      end
      if (busy_ev.exists(cyc)) mbusy = busy_ev[cyc];
    end
    chk("valid",     32'(u_if.o_valid),     32'(mv));
    chk("frame_err", 32'(u_if.o_frame_err), 32'(mfe));
    chk("overrun",   32'(u_if.o_overrun),   32'(mov));
    chk("busy",      32'(u_if.o_busy),      32'(mbusy));
    if (mv) chk("data", 32'(u_if.o_data), 32'(md));
    else if (!reset_n) chk("data_rst", 32'(u_if.o_data), 32'h0);
    h_valid[cyc] = u_if.o_valid;
    h_fe[cyc]    = u_if.o_frame_err;
    h_ov[cyc]    = u_if.o_overrun;
    h_busy[cyc]  = u_if.o_busy;
    h_data[cyc]  = u_if.o_data;
    rdy_prev     = u_if.i_ready;
  end

  task automatic drive(input logic v, input int n);
    u_if.i_rx = v;
    repeat (n) begin
      if (rand_ready) u_if.i_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Starts at cycle k; the line falls in cycle k, rx_s in k+2, decision lands at k+155.
  task automatic send_frame(input logic [7:0] b, input logic sb, input int extra);
    int k;
    k = cyc;
    busy_ev[k + 3] = 1'b1;
    if (sb) begin
      ev_kind[k + 155] = 1;
      ev_byte[k + 155] = b;
      busy_ev[k + 155] = 1'b0;
    end else begin
      ev_kind[k + 155]         = 2;
      busy_ev[k + 163 + extra] = 1'b0;
    end
    drive(1'b0, 16);
    for (int j = 0; j < 8; j++) drive(b[j], 16);
    drive(sb, 16);
    if (!sb) drive(1'b0, extra);
    u_if.i_rx = 1'b1;
  endtask

  task automatic glitch(input int n);
    int k;
    k = cyc;
    busy_ev[k + 3]  = 1'b1;
    busy_ev[k + 11] = 1'b0;
    drive(1'b0, n);
    u_if.i_rx = 1'b1;
  endtask

  task automatic reset_mid_frame(input logic [7:0] b);
    int k;
    k = cyc;
    busy_ev[k + 3] = 1'b1;
    drive(1'b0, 16);
    for (int j = 0; j < 4; j++) drive(b[j], 16);
    drive(b[4], 8);
    reset_n = 1'b0;
    #1;
    chk("rst_now_valid", 32'(u_if.o_valid), 32'h0);
    chk("rst_now_data",  32'(u_if.o_data),  32'h0);
    chk("rst_now_busy",  32'(u_if.o_busy),  32'h0);
    drive(b[4], 8);
    drive(b[5], 16);
    drive(b[6], 4);
    reset_n = 1'b1;
    drive(b[6], 12);
    drive(b[7], 16);
    drive(1'b1, 16);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, gap;
    logic sb;
    u_if.i_rx    = 1'b1;
    u_if.i_ready = 1'b1;
    reset_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(u_if.o_valid),     32'h0);
    chk("reset_data",  32'(u_if.o_data),      32'h0);
    chk("reset_fe",    32'(u_if.o_frame_err), 32'h0);
    chk("reset_ov",    32'(u_if.o_overrun),   32'h0);
    chk("reset_busy",  32'(u_if.o_busy),      32'h0);
    reset_n = 1'b1;
    drive(1'b1, 5);

    // Plain frame, consumer always ready.
    k = cyc;
    send_frame(8'hA5, 1'b1, 0);
    drive(1'b1, 4);
    chk("a5_before", 32'(h_valid[k + 154]), 32'h0);
    chk("a5_valid",  32'(h_valid[k + 155]), 32'h1);
    chk("a5_data",   32'(h_data[k + 155]),  32'hA5);
    chk("a5_after",  32'(h_valid[k + 156]), 32'h0);

    // Short low glitch.
    k = cyc;
    glitch(4);
    drive(1'b1, 12);
    chk("glitch_busy_hi", 32'(h_busy[k + 10]), 32'h1);
    chk("glitch_busy_lo", 32'(h_busy[k + 11]), 32'h0);

    // Framing error with a break, then a clean frame.
    k = cyc;
    send_frame(8'h3C, 1'b0, 40);
    drive(1'b1, 3);
    k2 = cyc;
    send_frame(8'h55, 1'b1, 0);
    drive(1'b1, 4);
    chk("fe_pulse",  32'(h_fe[k + 155]),     32'h1);
    chk("fe_break",  32'(h_busy[k + 190]),   32'h1);
    chk("55_data",   32'(h_data[k2 + 155]),  32'h55);

    // Overrun while the consumer stalls.
    u_if.i_ready = 1'b0;
    drive(1'b1, 2);
    k = cyc;
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h34, 1'b1, 0);
    drive(1'b1, 3);
    chk("ovr_pulse", 32'(h_ov[k + 315]),    32'h1);
    chk("ovr_data",  32'(h_data[k + 316]),  32'h12);
    chk("ovr_valid", 32'(h_valid[k + 316]), 32'h1);
    u_if.i_ready = 1'b1;
    drive(1'b1, 3);
    chk("ovr_drain", 32'(h_valid[cyc - 1]), 32'h0);

    // Back-to-back frames with one stop bit.
    k = cyc;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h81, 1'b1, 0);
    drive(1'b1, 4);
    chk("b2b_0", 32'(h_data[k + 155]), 32'h00);
    chk("b2b_1", 32'(h_data[k + 315]), 32'hFF);
    chk("b2b_2", 32'(h_data[k + 475]), 32'h81);

    // Reset in the middle of a frame while a byte is pending.
    u_if.i_ready = 1'b0;
    send_frame(8'h99, 1'b1, 0);
    drive(1'b1, 3);
    reset_mid_frame(8'hC3);
    drive(1'b1, 3);
    k = cyc;
    send_frame(8'h7E, 1'b1, 0);
    drive(1'b1, 4);
    chk("7e_data",  32'(h_data[k + 155]),  32'h7E);
    chk("7e_valid", 32'(h_valid[k + 155]), 32'h1);

    // Randomised frames, gaps, stop errors and consumer back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      sb = ($urandom_range(0, 5) != 0);
      send_frame(8'($urandom), sb, sb ? 0 : int'($urandom_range(0, 30)));
      gap = int'($urandom_range(sb ? 0 : 1, 15));
      if (gap > 0) drive(1'b1, gap);
    end
    rand_ready   = 1'b0;
    u_if.i_ready = 1'b1;
    drive(1'b1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
